div_core: RTL and testbench
===========================

# div_core

Parametrised multi-cycle integer divider for the EX stage, the next generation of the pipeline's fixed 32-bit divide unit. It accepts a signed or unsigned divide request over a start/ready handshake and runs one restoring-division iteration per cycle. It returns remainder and quotient packed into a double-width result. EX holds `start_i` and requests a pipeline stall until `ready_o`; `annul_i` aborts an in-flight divide on flush.

## Interface
- `WIDTH`, 32: operand width in bits, at least 4; result is 2·`WIDTH`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `signed_i`  in  1  1 = two's-complement divide, 0 = unsigned; sampled with `start_i` in IDLE.
- `opdata1_i`  in  `WIDTH`  dividend; sampled with `start_i` in IDLE.
- `opdata2_i`  in  `WIDTH`  divisor; sampled with `start_i` in IDLE.
- `start_i`  in  1  request; held high by EX until `ready_o` is seen.
- `annul_i`  in  1  abort the current operation.
- `result_o`  out  2·`WIDTH`  {remainder, quotient}; remainder in the upper half.
- `ready_o`  out  1  result valid.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE
  - DIVZERO (only with the macro)
  - BUSY
  - DONE
- Iteration counter: `$clog2(WIDTH)+1` bits.
- IDLE, `start_i`=1 and `annul_i`=0:
  - Latch operands and mode.
  - Store magnitudes: in signed mode, a negative operand is negated; otherwise operands are taken as-is.
  - Record sign of quotient (sa^sb) and sign of remainder (sa).
  - Go to BUSY with counter 0. With the macro and divisor = 0, go to DIVZERO instead.
- BUSY, each cycle:
  - Shift {partial remainder, dividend} left by one.
  - Trial-subtract the divisor magnitude on `WIDTH`+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; else shift in 0.
  - After `WIDTH` iterations, apply sign correction, register `result_o`, go to DONE.
- Sign correction (signed mode, divisor ≠ 0):
  - Negate the quotient if sa^sb.
  - Negate the remainder if sa.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
- Divisor = 0 (any mode): quotient = all ones, remainder = original dividend, no sign correction. This result is identical with or without the macro.
- Overflow: MIN / −1 in signed mode gives quotient = MIN (wraps), remainder = 0. No flag.
- DONE:
  - `ready_o`=1; `result_o` is held stable.
  - Stay while `start_i`=1.
  - When `start_i`=0, go to IDLE; `ready_o` drops the cycle after.
- Abort: in BUSY or DIVZERO, `annul_i`=1 or `start_i`=0 sends the block to IDLE on the next edge. `ready_o` stays 0 and `result_o` keeps its previous value.
- `annul_i` in DONE: go to IDLE.
- IDLE with `start_i`=0: no state change; `result_o` holds its last value.

## Timing
- Reset (async, immediate): state IDLE, counter 0, `result_o`=0, `ready_o`=0, `busy_o`=0.
- All outputs are registered.
- Normal latency:
  - Start is sampled at edge E0.
  - BUSY iterates on edges E1..E`WIDTH`.
  - `ready_o`=1 after edge E`WIDTH`, i.e. `WIDTH`+1 edges from acceptance (33 for `WIDTH`=32).
- Divide-by-zero with the macro: E0 → DIVZERO, E1 → DONE, so `ready_o` is high after 2 edges.
- Back-to-back operations: at least one IDLE cycle between DONE and the next acceptance. Start cannot be accepted in DONE.
- Reset asserted mid-BUSY clears everything in the same cycle; after deassertion the block sits in IDLE.

## Configuration
- `DIV_FAST_ZERO_EN` defined:
  - Divisor = 0 is detected in IDLE and routed through the DIVZERO state.
  - Completes in 2 edges with the defined result.
- `DIV_FAST_ZERO_EN` undefined:
  - No DIVZERO state.
  - Divisor = 0 runs the full `WIDTH` iterations; the restoring algorithm naturally yields all-ones and the dividend.
  - Sign correction is still suppressed.
  - Latency is `WIDTH`+1.

## Test plan
All scenarios use `WIDTH`=32.
- Unsigned 100 / 7 → `result_o` = {0x00000002, 0x0000000E}; `ready_o` high exactly 33 edges after start is sampled; `busy_o` high throughout.
- Signed 0xFFFFFFF9 / 0x00000002 (−7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; the same operands unsigned → quotient 0, remainder 0x80000000.
- 0x12345678 / 0, signed → quotient 0xFFFFFFFF, remainder 0x12345678; `ready_o` after 2 edges with `DIV_FAST_ZERO_EN`, 33 without.
- Assert `annul_i` at BUSY iteration 10 → `ready_o` never rises, `busy_o` low next edge. Then 20 / 5 unsigned → {0, 4} after 33 edges.
- Hold `start_i` 3 cycles in DONE → `result_o` stable, `ready_o` high; drop it → IDLE next edge. Assert `rst` mid-BUSY → all outputs 0 immediately.

Source files
------------

// File: rtl/div_core.sv
// Multi-cycle restoring integer divider (signed/unsigned), one quotient bit per cycle.
// Optional DIV_FAST_ZERO_EN routes divide-by-zero through a short DIVZERO state.
module div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
`ifdef DIV_FAST_ZERO_EN
    S_DIVZERO = 2'd1,
`endif
    S_BUSY    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dvs;
  logic [WIDTH-1:0]     r_opa;
  logic                 r_qneg;
  logic                 r_rneg;
  logic                 r_divzero;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;
  logic                 r_busy;

  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_rem_nx;
  logic [WIDTH-1:0]     w_quo_nx;
  logic [WIDTH-1:0]     w_q_fin;
  logic [WIDTH-1:0]     w_r_fin;
  logic                 w_abort;
  logic                 w_last;

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = r_busy;

  // Operand magnitudes and signs for a request presented in IDLE.
  always_comb begin
    w_sa    = signed_i & opdata1_i[WIDTH-1];
    w_sb    = signed_i & opdata2_i[WIDTH-1];
    w_mag_a = w_sa ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    w_mag_b = w_sb ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
  end

  // One restoring step: shift, trial-subtract on WIDTH+1 bits, keep if non-negative.
  always_comb begin
    w_shift  = {r_rem, r_quo[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_dvs};
    w_rem_nx = w_shift[WIDTH-1:0];
    w_quo_nx = {r_quo[WIDTH-2:0], 1'b0};
    if (!w_diff[WIDTH]) begin
      w_rem_nx = w_diff[WIDTH-1:0];
      w_quo_nx = {r_quo[WIDTH-2:0], 1'b1};
    end
  end

  // Divide-by-zero bypasses sign correction and returns the untouched dividend.
  always_comb begin
    w_q_fin = w_quo_nx;
    w_r_fin = w_rem_nx;
    if (r_divzero) begin
      w_q_fin = {WIDTH{1'b1}};
      w_r_fin = r_opa;
    end else begin
      if (r_qneg) w_q_fin = ~w_quo_nx + WIDTH'(1);
      if (r_rneg) w_r_fin = ~w_rem_nx + WIDTH'(1);
    end
  end

  assign w_abort = annul_i | ~start_i;
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_opa     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_divzero <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            r_opa     <= opdata1_i;
            r_rem     <= '0;
            r_quo     <= w_mag_a;
            r_dvs     <= w_mag_b;
            r_qneg    <= w_sa ^ w_sb;
            r_rneg    <= w_sa;
            r_divzero <= (opdata2_i == '0);
            r_cnt     <= '0;
            r_busy    <= 1'b1;
`ifdef DIV_FAST_ZERO_EN
            if (opdata2_i == '0) r_state <= S_DIVZERO;
            else                 r_state <= S_BUSY;
`else
            r_state   <= S_BUSY;
`endif
          end
        end
`ifdef DIV_FAST_ZERO_EN
        S_DIVZERO: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_result <= {r_opa, {WIDTH{1'b1}}};
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
`endif
        S_BUSY: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= {w_r_fin, w_q_fin};
              r_ready  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_core.sv
// Self-checking bench for div_core (WIDTH=32): directed table, corner sequences, random vs model.
// Expected divide-by-zero latency follows DIV_FAST_ZERO_EN.
module tb_div_core;

  localparam int W    = 32;
  localparam int NLAT = W + 1;
`ifdef DIV_FAST_ZERO_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  div_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic with the divide-by-zero and overflow rules.
  function automatic logic [63:0] model(input bit s, input logic [31:0] x, input logic [31:0] y);
    int sx;
    int sy;
    int q;
    int r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (!s) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sx = $signed(x);
    sy = $signed(y);
    q  = sx / sy;
    r  = sx % sy;
    return {32'(r), 32'(q)};
  endfunction

  // Issue one divide, wait for ready (bounded), optionally hold start in DONE, then release.
  task automatic run_op(input bit s, input logic [31:0] x, input logic [31:0] y, input int hold,
                        output logic [63:0] res, output int edges);
    bit busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    signed_i  = s;
    opdata1_i = x;
    opdata2_i = y;
    start_i   = 1'b1;
    edges     = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (!ready_o && !busy_o) busy_ok = 1'b0;
    end while (!ready_o && edges < 200);
    res = result_o;
    chk("ready_seen", 64'(ready_o), 64'd1);
    chk("busy_while_running", 64'(busy_ok), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("done_hold_ready", 64'(ready_o), 64'd1);
      chk("done_hold_result", result_o, res);
    end
    @(negedge clk);
    start_i   = 1'b0;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    @(posedge clk);
    #1;
    chk("release_ready", 64'(ready_o), 64'd0);
    chk("release_busy", 64'(busy_o), 64'd0);
    chk("release_result_held", result_o, res);
  endtask

  typedef struct {
    string        name;
    bit           s;
    logic [31:0]  x;
    logic [31:0]  y;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    logic [63:0] last_res;
    logic [31:0] x;
    logic [31:0] y;
    bit          s;
    int          lat;

    vecs[0] = '{"u_100_div_7",      1'b0, 32'd100,        32'd7,        {32'd2,          32'd14}};
    vecs[1] = '{"s_m7_div_2",       1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
    vecs[2] = '{"s_7_div_m2",       1'b1, 32'd7,          32'hFFFF_FFFE,{32'd1,          32'hFFFF_FFFD}};
    vecs[3] = '{"s_min_div_m1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,{32'd0,          32'h8000_0000}};
    vecs[4] = '{"u_min_div_ffff",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,{32'h8000_0000,  32'd0}};
    vecs[5] = '{"s_div_zero",       1'b1, 32'h1234_5678,  32'd0,        {32'h1234_5678,  32'hFFFF_FFFF}};
    vecs[6] = '{"s_neg_div_zero",   1'b1, 32'hFFFF_FFF9,  32'd0,        {32'hFFFF_FFF9,  32'hFFFF_FFFF}};
    vecs[7] = '{"u_div_zero",       1'b0, 32'hF000_0000,  32'd0,        {32'hF000_0000,  32'hFFFF_FFFF}};
    vecs[8] = '{"s_m100_div_m7",    1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,{32'hFFFF_FFFE,  32'd14}};

    rst       = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i   = 1'b0;
    annul_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start with annul in IDLE must not be accepted.
    @(negedge clk);
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    @(posedge clk);
    #1;
    chk("idle_annul_not_accepted", 64'(busy_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].x, vecs[i].y, 0, res, lat);
      chk(vecs[i].name, res, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, 64'(lat), (vecs[i].y == 32'd0) ? 64'(ZLAT) : 64'(NLAT));
    end
    last_res = vecs[8].exp;

    // Annul at BUSY iteration 10: no ready, busy drops next edge, result held.
    @(negedge clk);
    signed_i  = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    @(posedge clk);
    lat = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ready_o) lat++;
    end
    chk("annul_no_early_ready", 64'(lat), 64'd0);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_busy_low", 64'(busy_o), 64'd0);
    chk("annul_ready_low", 64'(ready_o), 64'd0);
    chk("annul_result_held", result_o, last_res);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready_low", 64'(ready_o), 64'd0);
    chk("idle_result_held", result_o, last_res);
    run_op(1'b0, 32'd20, 32'd5, 0, res, lat);
    chk("u_20_div_5", res, {32'd0, 32'd4});
    chk("u_20_div_5_latency", 64'(lat), 64'(NLAT));

    // Start held three cycles in DONE: stable, and no second acceptance.
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 3, res, lat);
    chk("hold_result", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // Reset mid-BUSY clears outputs immediately.
    @(negedge clk);
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midbusy_rst_result", result_o, 64'd0);
    chk("midbusy_rst_ready", 64'(ready_o), 64'd0);
    chk("midbusy_rst_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(busy_o), 64'd0);

    // Randomized operations against the model.
    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom);
      x = $urandom;
      case ($urandom_range(0, 4))
        0:       y = $urandom;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'd0 - 32'($urandom_range(1, 9));
        3:       y = 32'd0;
        default: y = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      run_op(s, x, y, 0, res, lat);
      chk("random_result", res, model(s, x, y));
      chk("random_latency", 64'(lat), (y == 32'd0) ? 64'(ZLAT) : 64'(NLAT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
